fetch_predecode: RTL

- Instruction fetch and pre-decode stage that sits directly upstream of the immediate generator.
- Owns the PC and issues word fetches to a fixed 1-cycle-latency instruction memory.
- Buffers returned instructions in a small FIFO and classifies each one's immediate format.
- Hands {instr, pc, imm_sel} to decode over a valid/ready handshake; imm_sel feeds the immediate generator directly.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_predecode.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V opcode and immediate-format encodings for the fetch/decode front end.
package rv_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head read straight from the storage flops.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 67,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  // Flush dominates: a coincident push or pop is discarded.
  assign push_en = push_i & ~flush_i;
  assign pop_en  = pop_i & ~flush_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_predecode.sv
// Fetch stage: owns the PC, fetches from 1-cycle imem, buffers and tags each word's immediate format.
// Define FETCH_ILLEGAL_EN to add the id_illegal output carried alongside each buffered entry.
module fetch_predecode
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned K        = 3
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc,
  output logic [K-1:0] id_imm_sel
`ifdef FETCH_ILLEGAL_EN
  ,
  output logic         id_illegal
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
`ifdef FETCH_ILLEGAL_EN
  localparam int unsigned IllW = 1;
`else
  localparam int unsigned IllW = 0;
`endif
  localparam int unsigned EntryW = 64 + K + IllW;

  function automatic logic [2:0] imm_class(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: imm_class = IMM_I;
      OP_STORE:                                      imm_class = IMM_S;
      OP_BRANCH:                                     imm_class = IMM_B;
      OP_LUI, OP_AUIPC:                              imm_class = IMM_U;
      OP_JAL:                                        imm_class = IMM_J;
      default:                                       imm_class = IMM_NONE;
    endcase
  endfunction

`ifdef FETCH_ILLEGAL_EN
  function automatic logic is_illegal(input logic [6:0] opcode);
    is_illegal = (opcode[1:0] != 2'b11) || ((imm_class(opcode) == IMM_NONE) && (opcode != OP_REG));
  endfunction
`endif

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_pc_q;
  logic              inflight_q;
  logic              drop_q, drop_d;
  logic [CntW-1:0]   count;
  logic              pop, push;
  logic [31:0]       occupancy;
  logic [EntryW-1:0] wdata, rdata;
  logic              unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign pop       = id_valid & id_ready;
  assign push      = imem_rvalid & ~drop_q;
  assign occupancy = 32'(count) + 32'(inflight_q) - 32'(pop);
  assign imem_req  = ~rst & ~redirect_valid & (occupancy < DEPTH);
  assign imem_addr = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (imem_req) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // An in-flight response normally lands in the redirect cycle itself and is flushed there;
  // drop only guards a response still outstanding after the redirect.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = inflight_q & ~imem_rvalid;
    end else if (imem_rvalid) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      drop_q     <= drop_d;
      if (imem_req) req_pc_q <= pc_q;
    end
  end

`ifdef FETCH_ILLEGAL_EN
  assign wdata      = {is_illegal(imem_rdata[6:0]), K'(imm_class(imem_rdata[6:0])), req_pc_q,
                       imem_rdata};
  assign id_illegal = rdata[EntryW-1];
`else
  assign wdata      = {K'(imm_class(imem_rdata[6:0])), req_pc_q, imem_rdata};
`endif

  fetch_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .valid_o (id_valid),
    .count_o (count)
  );

  assign id_instr   = rdata[31:0];
  assign id_pc      = rdata[63:32];
  assign id_imm_sel = rdata[64 +: K];

endmodule
